// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: fetch pointer, 2-entry fetch queue and a REQ/DRAIN
// FSM that discards the one response still in flight after a redirect.
// Optional feature: define IF_STALL_COUNT_EN to enable the empty-queue cycle
// counter on stall_count (otherwise stall_count is tied to 0).
module if_fetch_stage #(
  parameter int unsigned BIT_NUMBER = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [BIT_NUMBER-1:0] branch_addr,
  output logic                  imem_req,
  output logic [BIT_NUMBER-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [BIT_NUMBER-1:0] imem_rdata,
  output logic [BIT_NUMBER-1:0] pc,
  output logic [BIT_NUMBER-1:0] instruction,
  output logic                  valid,
  output logic [31:0]           stall_count
);

  localparam int unsigned W  = BIT_NUMBER;
  localparam int unsigned CW = 2;

  typedef enum logic {
    ST_REQ   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    fpc_q, fpc_d;
  logic [W-1:0]    drain_addr_q, drain_addr_d;
  logic            outst_q, outst_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    e0_pc_q, e0_pc_d, e0_ins_q, e0_ins_d;
  logic [W-1:0]    e1_pc_q, e1_pc_d, e1_ins_q, e1_ins_d;
  logic            push_c, pop_c;
  logic [W-1:0]    new_pc_c;

  // Memory request interface and queue-head outputs (NOP bubble when empty)
  always_comb begin
    imem_req    = !rst && ((state_q == ST_DRAIN) || (cnt_q < CW'(2)) || outst_q);
    imem_addr   = (state_q == ST_DRAIN) ? drain_addr_q : fpc_q;
    valid       = (cnt_q != CW'(0));
    pc          = valid ? e0_pc_q  : W'(0);
    instruction = valid ? e0_ins_q : W'(0);
  end

  // Next-state: redirect priority, queue push/pop and drain handling
  always_comb begin
    state_d      = state_q;
    fpc_d        = fpc_q;
    drain_addr_d = drain_addr_q;
    outst_d      = outst_q;
    cnt_d        = cnt_q;
    e0_pc_d      = e0_pc_q;
    e0_ins_d     = e0_ins_q;
    e1_pc_d      = e1_pc_q;
    e1_ins_d     = e1_ins_q;
    push_c       = 1'b0;
    pop_c        = 1'b0;
    new_pc_c     = fpc_q + W'(4);

    unique case (state_q)
      ST_REQ: begin
        if (branch_taken) begin
          cnt_d   = CW'(0);
          fpc_d   = branch_addr;
          outst_d = 1'b0;
          // A response still owed by memory must be swallowed first
          if (imem_req && !imem_ready) begin
            state_d      = ST_DRAIN;
            drain_addr_d = fpc_q;
          end
        end else begin
          push_c  = imem_req && imem_ready;
          pop_c   = valid && !freeze;
          outst_d = imem_req && !imem_ready;
          if (push_c) begin
            fpc_d = new_pc_c;
          end
          unique case ({push_c, pop_c})
            2'b10: begin
              if (cnt_q == CW'(0)) begin
                e0_pc_d  = new_pc_c;
                e0_ins_d = imem_rdata;
              end else begin
                e1_pc_d  = new_pc_c;
                e1_ins_d = imem_rdata;
              end
              cnt_d = cnt_q + CW'(1);
            end
            2'b01: begin
              e0_pc_d  = e1_pc_q;
              e0_ins_d = e1_ins_q;
              cnt_d    = cnt_q - CW'(1);
            end
            2'b11: begin
              if (cnt_q == CW'(1)) begin
                e0_pc_d  = new_pc_c;
                e0_ins_d = imem_rdata;
              end else begin
                e0_pc_d  = e1_pc_q;
                e0_ins_d = e1_ins_q;
                e1_pc_d  = new_pc_c;
                e1_ins_d = imem_rdata;
              end
            end
            default: ;
          endcase
        end
      end
      ST_DRAIN: begin
        if (branch_taken) begin
          fpc_d = branch_addr;
        end
        if (imem_ready) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REQ;
      fpc_q        <= W'(0);
      drain_addr_q <= W'(0);
      outst_q      <= 1'b0;
      cnt_q        <= CW'(0);
      e0_pc_q      <= W'(0);
      e0_ins_q     <= W'(0);
      e1_pc_q      <= W'(0);
      e1_ins_q     <= W'(0);
    end else begin
      state_q      <= state_d;
      fpc_q        <= fpc_d;
      drain_addr_q <= drain_addr_d;
      outst_q      <= outst_d;
      cnt_q        <= cnt_d;
      e0_pc_q      <= e0_pc_d;
      e0_ins_q     <= e0_ins_d;
      e1_pc_q      <= e1_pc_d;
      e1_ins_q     <= e1_ins_d;
    end
  end

`ifdef IF_STALL_COUNT_EN
  logic [31:0] stall_q;

  // Count non-reset cycles in which the queue is empty
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else if (!valid) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: queue-based reference model plus a wait-state
// memory model, directed scenarios and a randomized run.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken, imem_req, imem_ready, valid;
  logic [31:0] branch_addr, imem_addr, imem_rdata, pc, instruction, stall_count;

  always #5 clk = ~clk;

  if_fetch_stage #(.BIT_NUMBER(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc),
    .instruction(instruction), .valid(valid), .stall_count(stall_count)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  // reference model: expected queue contents and fetch pointer
  ent_t        mq[$];
  logic [31:0] m_fpc, m_daddr, m_stall;
  bit          m_drain, m_outst;

  // memory model
  bit          mem_busy, mem_rand;
  int          mem_left, mem_wait;
  logic [31:0] mem_addr, mem_key;

  // current-cycle stimulus and expectations
  bit          c_rst, c_fr, c_br, c_rdy;
  logic [31:0] c_ba, c_rdata;
  logic        e_req, e_valid;
  logic [31:0] e_addr, e_pc, e_ins;
  logic [129:0] exp_vec;

  function automatic logic [129:0] act_vec();
    return {imem_req, imem_addr, valid, pc, instruction, stall_count};
  endfunction

  // Apply one cycle of stimulus and compute the expected outputs
  task automatic drive(input bit r, input bit fr, input bit br, input logic [31:0] ba);
    c_rst = r; c_fr = fr; c_br = br; c_ba = ba;
    rst = r; freeze = fr; branch_taken = br; branch_addr = ba;
    e_valid = (mq.size() != 0);
    e_pc    = e_valid ? mq[0].pc  : 32'd0;
    e_ins   = e_valid ? mq[0].ins : 32'd0;
    e_req   = !r && (m_drain || mq.size() < 2 || m_outst);
    e_addr  = m_drain ? m_daddr : m_fpc;
    if (e_req && !mem_busy) begin
      mem_busy = 1'b1;
      mem_addr = e_addr;
      mem_left = mem_rand ? int'($urandom_range(3, 0)) : mem_wait;
    end
    c_rdy   = mem_busy && (mem_left == 0) && !r;
    c_rdata = c_rdy ? (mem_addr ^ mem_key) : $urandom;
    imem_ready = c_rdy;
    imem_rdata = c_rdata;
    exp_vec = {e_req, e_addr, e_valid, e_pc, e_ins, m_stall};
    #1;
  endtask

  // Clock edge: advance the reference and memory models
  task automatic advance();
    ent_t e;
    @(posedge clk);
    if (c_rst) begin
      m_fpc = 0; mq.delete(); m_drain = 0; m_outst = 0; m_stall = 0;
      mem_busy = 0;
    end else begin
`ifdef IF_STALL_COUNT_EN
      if (!e_valid) m_stall = m_stall + 32'd1;
`endif
      if (mem_busy) begin
        if (c_rdy) mem_busy = 0;
        else mem_left--;
      end
      if (m_drain) begin
        if (c_br) m_fpc = c_ba;
        if (c_rdy) m_drain = 0;
      end else if (c_br) begin
        mq.delete();
        m_outst = 0;
        if (e_req && !c_rdy) begin
          m_drain = 1;
          m_daddr = m_fpc;
        end
        m_fpc = c_ba;
      end else begin
        if (mq.size() != 0 && !c_fr) void'(mq.pop_front());
        if (c_rdy) begin
          e.pc  = m_fpc + 32'd4;
          e.ins = c_rdata;
          mq.push_back(e);
          m_fpc = m_fpc + 32'd4;
        end
        m_outst = e_req && !c_rdy;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    mem_rand = 0; mem_wait = 0; mem_key = 0;
    drive(1, 0, 0, 32'h0);
    total++;
    if (act_vec() !== exp_vec) begin
      bad++; $display("FAIL reset_vec act=%h exp=%h", act_vec(), exp_vec);
    end
    total++;
    if ({imem_req, valid, pc, instruction, stall_count} !== 98'd0) begin
      bad++; $display("FAIL reset_zero req=%b valid=%b pc=%h ins=%h stall=%0d want all 0",
                      imem_req, valid, pc, instruction, stall_count);
    end
    advance();
    drive(0, 0, 0, 32'h0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL reset_first_req req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
    advance();
  endtask

  task automatic test_stream();
    mem_rand = 0; mem_wait = 0; mem_key = 0;
    drive(1, 0, 0, 32'h0); advance();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 0, 32'h0);
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("FAIL stream_vec cyc=%0d act=%h exp=%h", k, act_vec(), exp_vec);
      end
      if (k >= 2 && k <= 4) begin
        total++;
        if ({valid, pc, instruction} !== {1'b1, 32'(4 * (k - 1)), 32'(4 * (k - 2))}) begin
          bad++; $display("FAIL stream_pair cyc=%0d act=%b/%h/%h want 1/%h/%h", k, valid, pc,
                          instruction, 32'(4 * (k - 1)), 32'(4 * (k - 2)));
        end
      end
      advance();
    end
  endtask

  task automatic test_freeze();
    logic [31:0] last_pc;
    mem_rand = 0; mem_wait = 0; mem_key = 0;
    drive(1, 0, 0, 32'h0); advance();
    last_pc = 32'h0;
    for (int k = 1; k <= 14; k++) begin
      bit fr;
      fr = (k >= 3 && k <= 7);
      drive(0, fr, 0, 32'h0);
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("FAIL freeze_vec cyc=%0d act=%h exp=%h", k, act_vec(), exp_vec);
      end
      if (fr) begin
        total++;
        if (pc !== 32'd8 || valid !== 1'b1) begin
          bad++; $display("FAIL freeze_hold cyc=%0d pc=%h valid=%b want 00000008 1", k, pc, valid);
        end
      end
      if (k >= 4 && k <= 7) begin
        total++;
        if (imem_req !== 1'b0) begin
          bad++; $display("FAIL freeze_req_drop cyc=%0d req=%b want 0", k, imem_req);
        end
      end
      if (valid && !fr) begin
        total++;
        if (pc !== last_pc + 32'd4 || instruction !== last_pc) begin
          bad++; $display("FAIL freeze_order cyc=%0d pc=%h ins=%h want %h %h", k, pc,
                          instruction, last_pc + 32'd4, last_pc);
        end
        last_pc = last_pc + 32'd4;
      end
      advance();
    end
  endtask

  task automatic test_branch();
    mem_rand = 0; mem_wait = 0; mem_key = 0;
    drive(1, 0, 0, 32'h0); advance();
    for (int k = 1; k <= 7; k++) begin
      drive(0, (k == 3 || k == 4), (k == 4), 32'h100);
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("FAIL branch_vec cyc=%0d act=%h exp=%h", k, act_vec(), exp_vec);
      end
      if (k == 5) begin
        total++;
        if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
          bad++; $display("FAIL branch_flush valid=%b req=%b addr=%h want 0 1 00000100",
                          valid, imem_req, imem_addr);
        end
      end
      if (k == 6) begin
        total++;
        if (valid !== 1'b1 || pc !== 32'h104 || instruction !== 32'h100) begin
          bad++; $display("FAIL branch_first valid=%b pc=%h ins=%h want 1 00000104 00000100",
                          valid, pc, instruction);
        end
      end
      advance();
    end
  endtask

  task automatic test_drain();
    bit seen;
    mem_rand = 0; mem_wait = 3; mem_key = 32'h5A5A_0000;
    drive(1, 0, 0, 32'h0); advance();
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      drive(0, 0, (k == 2), 32'h200);
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("FAIL drain_vec cyc=%0d act=%h exp=%h", k, act_vec(), exp_vec);
      end
      if (k == 3 || k == 4) begin
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0) begin
          bad++; $display("FAIL drain_hold cyc=%0d req=%b addr=%h valid=%b want 1 00000000 0",
                          k, imem_req, imem_addr, valid);
        end
      end
      if (k == 5) begin
        total++;
        if (imem_addr !== 32'h200) begin
          bad++; $display("FAIL drain_refetch addr=%h want 00000200", imem_addr);
        end
      end
      if (valid) begin
        seen = 1;
        total++;
        if (pc !== 32'h204 || instruction !== (32'h200 ^ 32'h5A5A_0000)) begin
          bad++; $display("FAIL drain_first pc=%h ins=%h want 00000204 %h", pc, instruction,
                          32'h200 ^ 32'h5A5A_0000);
        end
      end
      advance();
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL drain_timeout valid=%b want 1 within 20 cycles", valid);
    end
  endtask

  task automatic test_wrap();
    mem_rand = 0; mem_wait = 0; mem_key = 0;
    drive(1, 0, 0, 32'h0); advance();
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, (k == 1), 32'hFFFF_FFFC);
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("FAIL wrap_vec cyc=%0d act=%h exp=%h", k, act_vec(), exp_vec);
      end
      if (k == 3) begin
        total++;
        if (valid !== 1'b1 || pc !== 32'h0 || instruction !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
          bad++; $display("FAIL wrap_pc valid=%b pc=%h ins=%h addr=%h want 1 00000000 fffffffc 00000000",
                          valid, pc, instruction, imem_addr);
        end
      end
      advance();
    end
  endtask

  task automatic test_stall_count();
    logic [31:0] want;
`ifdef IF_STALL_COUNT_EN
    want = 32'd3;
`else
    want = 32'd0;
`endif
    mem_rand = 0; mem_wait = 2; mem_key = 0;
    drive(1, 0, 0, 32'h0); advance();
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 0, 32'h0);
      mem_wait = 0;
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("FAIL stall_vec cyc=%0d act=%h exp=%h", k, act_vec(), exp_vec);
      end
      advance();
    end
    total++;
    if (stall_count !== want) begin
      bad++; $display("FAIL stall_final stall_count=%0d want %0d", stall_count, want);
    end
  endtask

  task automatic test_random();
    mem_rand = 1; mem_key = $urandom;
    drive(1, 0, 0, 32'h0); advance();
    for (int k = 1; k <= 1500; k++) begin
      bit r, fr, br;
      logic [31:0] ba;
      r  = ($urandom_range(99, 0) == 0);
      fr = ($urandom_range(99, 0) < 30);
      br = ($urandom_range(99, 0) < 6);
      ba = $urandom & 32'hFFFF_FFFC;
      drive(r, fr, br, ba);
      total++;
      if (act_vec() !== exp_vec) begin
        bad++; $display("FAIL random_vec cyc=%0d act=%h exp=%h", k, act_vec(), exp_vec);
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    m_fpc = 0; m_daddr = 0; m_stall = 0; m_drain = 0; m_outst = 0;
    mem_busy = 0; mem_rand = 0; mem_left = 0; mem_wait = 0; mem_addr = 0; mem_key = 0;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_freeze();
    test_branch();
    test_drain();
    test_wrap();
    test_stall_count();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter BIT_NUMBER, default 32, datapath and address width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port freeze  input  1  hazard stall from downstream; the head entry is not consumed while high.
REQ-005 SHALL have port branch_taken  input  1  one-cycle redirect pulse from the execute stage.
REQ-006 SHALL have port branch_addr  input  BIT_NUMBER  redirect target address.
REQ-007 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-008 SHALL have port imem_addr  output  BIT_NUMBER  fetch address; stable while imem_req=1 and imem_ready=0.
REQ-009 SHALL have port imem_ready  input  1  imem_rdata is valid this cycle for imem_addr; may assert in the request cycle (zero wait).
REQ-010 SHALL have port imem_rdata  input  BIT_NUMBER  fetched instruction word.
REQ-011 SHALL have port pc  output  BIT_NUMBER  head entry fetch address + 4, feeding the IF/ID register pc input.
REQ-012 SHALL have port instruction  output  BIT_NUMBER  head entry instruction word.
REQ-013 SHALL have port valid  output  1  the fetch queue is non-empty.
REQ-014 SHALL have port stall_count  output  32  empty-queue cycle counter (see Configuration).

Function
REQ-015 SHALL hold a fetch pointer fpc and a 2-entry FIFO fetch queue of {fpc+4, instruction} pairs.
REQ-016 SHALL implement FSM states REQ (normal fetch) and DRAIN (discard one in-flight response).
REQ-017 In REQ, imem_req SHALL be 1 when the queue count < 2 or a request is outstanding; imem_addr = fpc.
REQ-018 A request is outstanding from the first cycle with imem_req=1, imem_ready=0, until the imem_ready cycle; it SHALL NOT be withdrawn or re-addressed meanwhile.
REQ-019 In REQ, with imem_ready=1 and branch_taken=0: push {fpc+4, imem_rdata}, fpc <= fpc+4 (modulo 2^BIT_NUMBER wrap).
REQ-020 Pop SHALL occur when valid=1 and freeze=0; simultaneous push and pop SHALL keep the count unchanged and preserve order.
REQ-021 With the queue empty, pc and instruction SHALL be 0 (NOP bubble) and valid SHALL be 0.
REQ-022 branch_taken=1 SHALL have priority over push, pop and freeze: queue flushed to 0 entries, fpc <= branch_addr, and any same-cycle imem_rdata discarded.
REQ-023 branch_taken=1 with a request outstanding and imem_ready=0 SHALL move to DRAIN; otherwise the FSM SHALL remain in or enter REQ.
REQ-024 In DRAIN, imem_req SHALL stay 1 with the old address; the imem_ready response SHALL be discarded, then the FSM SHALL return to REQ.
REQ-025 branch_taken=1 during DRAIN SHALL update fpc only and stay in DRAIN.
REQ-026 Latency: zero-wait memory, empty queue, freeze=0 -> valid=1 one cycle after the imem_ready edge; sustained throughput SHALL be 1 instruction/cycle.

Reset
REQ-027 With rst=1 at a clock edge: fpc=0, queue empty, FSM=REQ, valid=0, pc=0, instruction=0, stall_count=0.
REQ-028 Reset mid-request SHALL abandon the outstanding request without DRAIN; the memory is reset concurrently.
REQ-029 imem_req SHALL be 0 in the cycle rst is high, and in REQ from the first cycle after reset.

Configuration
REQ-030 With IF_STALL_COUNT_EN defined, stall_count SHALL increment (wrapping at 2^32) each non-reset cycle with valid=0; without it, stall_count SHALL be constant 0 with no counter logic.

Verification
REQ-031 Zero-wait memory returning word=address, freeze=0, after reset -> (pc, instruction) = (4,0),(8,4),(12,8) on successive cycles, valid=1.
REQ-032 freeze high 5 cycles with a continuous stream -> queue fills to 2, imem_req drops, head holds pc=8; after release, the stream resumes in order with no loss or duplicate.
REQ-033 branch_taken with branch_addr=0x100 while 2 entries are queued -> next cycle valid=0; the next issued imem_addr=0x100; first output pc=0x104.
REQ-034 3-wait-state memory, branch at cycle 1 of a wait -> DRAIN, imem_addr held, stale word discarded, then fetch from branch_addr.
REQ-035 fpc=0xFFFFFFFC fetch -> pc output 0x00000000, next imem_addr=0x00000000.
REQ-036 With IF_STALL_COUNT_EN: 3 empty cycles after reset then continuous flow -> stall_count=3 and holds; without it, stall_count=0 throughout.
